// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, IR field positions, FSM states and opcode classes for the control unit
package cpu_pkg;
  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;
  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_C_MSB  = 18;
  localparam int IR_C_LSB  = 0;
  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
  } state_e;
  typedef enum logic [2:0] {
    C_ALUR, C_ALUI, C_LD, C_LDI, C_ST, C_BR, C_HALT, C_NOP
  } class_e;
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: instruction/status inputs and datapath strobes of the control unit
interface control_unit_if;
  logic [31:0] IR;
  logic        CON;
  logic        mem_ready;
  logic        stop;
  logic        PCout, PCin, IncPC;
  logic        MARin, MDRin, MDRout, Read, Write;
  logic        IRin, Yin, ZLowIn, ZLowOut, CONin;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, RCout;
  logic [4:0]  alu_op;
  logic        run;
  modport master (
    input  IR, CON, mem_ready, stop,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write,
    output IRin, Yin, ZLowIn, ZLowOut, CONin,
    output Gra, Grb, Grc, Rin, Rout, BAout, RCout, alu_op, run
  );
  modport slave (
    output IR, CON, mem_ready, stop,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write,
    input  IRin, Yin, ZLowIn, ZLowOut, CONin,
    input  Gra, Grb, Grc, Rin, Rout, BAout, RCout, alu_op, run
  );
endinterface

// File: rtl/cu_decode.sv
// cu_decode: maps a 5-bit opcode to its execution class; unknown opcodes behave as NOP
module cu_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output class_e     cls
);
  // combinational opcode classification
  always_comb begin
    cls = C_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: cls = C_ALUR;
      OP_ADDI, OP_ANDI, OP_ORI:      cls = C_ALUI;
      OP_LD:                         cls = C_LD;
      OP_LDI:                        cls = C_LDI;
      OP_ST:                         cls = C_ST;
      OP_BR:                         cls = C_BR;
      OP_HALT:                       cls = C_HALT;
      default:                       cls = C_NOP;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: Moore sequencer driving fetch/execute strobes for the datapath
module control_unit
  import cpu_pkg::*;
(
  input  logic          clock,
  input  logic          clear,
  control_unit_if.master cu
);
  state_e     state_q, state_d, fetch_next;
  class_e     cls_q, cls_d, cls_dec;
  logic [4:0] op_q, op_d;
  logic       con_q, con_d;
  logic       alur, alui, ld, ldi, st, br, imm, wb5;
  logic       t0, t1, t2, t3, t4, t5, t6, t7;

  cu_decode u_decode (
    .opcode(cu.IR[IR_OP_MSB:IR_OP_LSB]),
    .cls   (cls_dec)
  );

  // state, latched opcode/class and latched branch condition
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_RESET;
      cls_q   <= C_NOP;
      op_q    <= '0;
      con_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      op_q    <= op_d;
      con_q   <= con_d;
    end
  end

  // next-state: class captured leaving T2, CON captured leaving T5, stop checked on entry to T0
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    op_d       = op_q;
    con_d      = con_q;
    fetch_next = cu.stop ? S_PAUSE : S_T0;
    case (state_q)
      S_RESET: state_d = fetch_next;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = cu.mem_ready ? S_T2 : S_T1;
      S_T2: begin
        cls_d   = cls_dec;
        op_d    = cu.IR[IR_OP_MSB:IR_OP_LSB];
        state_d = cls_dec == C_HALT ? S_HALT : cls_dec == C_NOP ? fetch_next : S_T3;
      end
      S_T3:    state_d = S_T4;
      S_T4:    state_d = S_T5;
      S_T5: begin
        con_d   = cu.CON;
        state_d = (cls_q == C_LD || cls_q == C_ST || cls_q == C_BR) ? S_T6 : fetch_next;
      end
      S_T6:    state_d = cls_q == C_BR ? fetch_next : cls_q == C_ST ? S_T7 :
                         cu.mem_ready ? S_T7 : S_T6;
      S_T7:    state_d = (cls_q == C_ST && !cu.mem_ready) ? S_T7 : fetch_next;
      S_PAUSE: state_d = cu.stop ? S_PAUSE : S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // output decode from state and latched class only
  always_comb begin
    t0   = state_q == S_T0;
    t1   = state_q == S_T1;
    t2   = state_q == S_T2;
    t3   = state_q == S_T3;
    t4   = state_q == S_T4;
    t5   = state_q == S_T5;
    t6   = state_q == S_T6;
    t7   = state_q == S_T7;
    alur = cls_q == C_ALUR;
    alui = cls_q == C_ALUI;
    ld   = cls_q == C_LD;
    ldi  = cls_q == C_LDI;
    st   = cls_q == C_ST;
    br   = cls_q == C_BR;
    imm  = alui | ldi | ld | st;
    wb5  = alur | alui | ldi;
    cu.PCout   = t0 | (t4 & br);
    cu.PCin    = t1 | (t6 & br & con_q);
    cu.IncPC   = t0;
    cu.MARin   = t0 | (t5 & (ld | st));
    cu.MDRin   = t1 | (t6 & (ld | st));
    cu.MDRout  = t2 | (t7 & ld);
    cu.Read    = t1 | (t6 & ld);
    cu.Write   = t7 & st;
    cu.IRin    = t2;
    cu.Yin     = (t3 & (alur | imm)) | (t4 & br);
    cu.ZLowIn  = t0 | (t4 & (alur | imm)) | (t5 & br);
    cu.ZLowOut = t1 | (t5 & (alur | imm)) | (t6 & br & con_q);
    cu.CONin   = t3 & br;
    cu.Gra     = (t5 & wb5) | (t7 & ld) | (t6 & st) | (t3 & br);
    cu.Grb     = t3 & (alur | imm);
    cu.Grc     = t4 & alur;
    cu.Rin     = (t5 & wb5) | (t7 & ld);
    cu.Rout    = (t3 & (alur | br)) | (t4 & alur) | (t6 & st);
    cu.BAout   = t3 & imm;
    cu.RCout   = (t4 & imm) | (t5 & br);
    cu.alu_op  = (t4 & (alur | alui)) ? op_q :
                 (t0 | (t4 & (ld | ldi | st)) | (t5 & br)) ? OP_ADD : 5'd0;
    cu.run     = !(state_q inside {S_RESET, S_PAUSE, S_HALT});
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard-driven directed bench for the control unit sequencer
module tb_control_unit;
  logic clock = 1'b0;
  logic clear = 1'b0;
  control_unit_if bus();
  control_unit dut (.clock(clock), .clear(clear), .cu(bus));
  always #5 clock = ~clock;

  localparam logic [19:0] PCOUT = 20'h80000, PCIN = 20'h40000, INCPC = 20'h20000, MARIN = 20'h10000;
  localparam logic [19:0] MDRIN = 20'h08000, MDROUT = 20'h04000, READ = 20'h02000, WRITE = 20'h01000;
  localparam logic [19:0] IRIN = 20'h00800, YIN = 20'h00400, ZLOWIN = 20'h00200, ZLOWOUT = 20'h00100;
  localparam logic [19:0] CONIN = 20'h00080, GRA = 20'h00040, GRB = 20'h00020, GRC = 20'h00010;
  localparam logic [19:0] RIN = 20'h00008, ROUT = 20'h00004, BAOUT = 20'h00002, RCOUT = 20'h00001;
  localparam logic [4:0]  ADD = 5'd3;

  typedef struct {
    logic [63:0] tag;
    logic [31:0] ir;
    logic        mr, con, stp;
    logic [25:0] exp;
  } ent_t;

  ent_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] cur_ir = '0;
  logic        cur_con = 1'b0;
  logic        cur_stp = 1'b0;

  function automatic logic [25:0] obs();
    return {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.Read, bus.Write,
            bus.IRin, bus.Yin, bus.ZLowIn, bus.ZLowOut, bus.CONin,
            bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.RCout, bus.alu_op, bus.run};
  endfunction

  task automatic add(input logic [63:0] tag, input logic [19:0] s, input logic [4:0] op,
                     input logic r, input logic mr);
    ent_t e;
    e.tag = tag; e.ir = cur_ir; e.mr = mr; e.con = cur_con; e.stp = cur_stp; e.exp = {s, op, r};
    sb.push_back(e);
  endtask

  task automatic chk0(input logic [63:0] tag);
    logic [25:0] o;
    o = obs();
    checks++;
    assert (o === 26'h0) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, 26'h0);
    end
  endtask

  task automatic drain();
    ent_t        e;
    logic [25:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.IR = e.ir; bus.CON = e.con; bus.stop = e.stp; bus.mem_ready = e.mr;
      o = obs();
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
      end
      @(negedge clock);
    end
  endtask

  task automatic fetch(input logic [31:0] ir, input int waits);
    cur_ir = ir;
    add("T0", PCOUT | MARIN | INCPC | ZLOWIN, ADD, 1, 1);
    repeat (waits) add("T1wait", ZLOWOUT | PCIN | READ | MDRIN, 0, 1, 0);
    add("T1", ZLOWOUT | PCIN | READ | MDRIN, 0, 1, 1);
    add("T2", MDROUT | IRIN, 0, 1, 1);
  endtask

  task automatic i_imm(input logic [31:0] ir, input logic [4:0] t4op);
    fetch(ir, 0);
    add("IMM_T3", GRB | BAOUT | YIN, 0, 1, 1);
    add("IMM_T4", RCOUT | ZLOWIN, t4op, 1, 1);
    add("IMM_T5", ZLOWOUT | GRA | RIN, 0, 1, 1);
  endtask

  task automatic i_alur(input logic [31:0] ir, input logic [4:0] op);
    fetch(ir, 1);
    add("R_T3", GRB | ROUT | YIN, 0, 1, 1);
    add("R_T4", GRC | ROUT | ZLOWIN, op, 1, 1);
    add("R_T5", ZLOWOUT | GRA | RIN, 0, 1, 1);
  endtask

  task automatic addr_t3_t5(input logic [31:0] ir, input int fw);
    fetch(ir, fw);
    add("A_T3", GRB | BAOUT | YIN, 0, 1, 1);
    add("A_T4", RCOUT | ZLOWIN, ADD, 1, 1);
    add("A_T5", ZLOWOUT | MARIN, 0, 1, 1);
  endtask

  task automatic i_br(input logic [31:0] ir, input logic taken);
    fetch(ir, 0);
    add("BR_T3", GRA | ROUT | CONIN, 0, 1, 1);
    add("BR_T4", PCOUT | YIN, 0, 1, 1);
    add("BR_T5", RCOUT | ZLOWIN, ADD, 1, 1);
    add("BR_T6", taken ? (ZLOWOUT | PCIN) : 20'h0, 0, 1, 1);
  endtask

  initial begin
    bus.IR = '0; bus.CON = 1'b0; bus.mem_ready = 1'b0; bus.stop = 1'b0;
    @(negedge clock);
    chk0("rst_a");
    @(negedge clock);
    chk0("rst_b");
    clear = 1'b1;
    add("RESET", 20'h0, 0, 0, 1);
    i_imm(32'h6918_0005, 5'd13);
    addr_t3_t5(32'h0090_0054, 0);
    repeat (3) add("LD_T6w", READ | MDRIN, 0, 1, 0);
    add("LD_T6", READ | MDRIN, 0, 1, 1);
    add("LD_T7", MDROUT | GRA | RIN, 0, 1, 1);
    addr_t3_t5(32'h1218_0087, 2);
    add("ST_T6", GRA | ROUT | MDRIN, 0, 1, 1);
    repeat (2) add("ST_T7w", WRITE, 0, 1, 0);
    add("ST_T7", WRITE, 0, 1, 1);
    i_alur(32'h1890_0000, 5'd3);
    i_alur(32'h2090_0000, 5'd4);
    i_imm(32'h0890_0010, ADD);
    i_imm(32'h7090_0001, 5'd14);
    cur_con = 1'b0;
    i_br(32'h9880_0010, 1'b0);
    cur_con = 1'b1;
    i_br(32'h9880_0010, 1'b1);
    cur_con = 1'b0;
    fetch(32'h3800_0000, 0);
    cur_stp = 1'b1;
    fetch(32'hD000_0000, 0);
    repeat (2) add("PAUSE", 20'h0, 0, 0, 1);
    cur_stp = 1'b0;
    add("PAUSEx", 20'h0, 0, 0, 1);
    cur_stp = 1'b1;
    fetch(32'hD800_0000, 0);
    repeat (20) add("HALT", 20'h0, 0, 0, 1);
    drain();
    cur_stp = 1'b0;
    bus.stop = 1'b0;
    clear = 1'b0;
    #1 chk0("clr_halt");
    @(negedge clock);
    clear = 1'b1;
    add("RESET2", 20'h0, 0, 0, 1);
    addr_t3_t5(32'h0090_0054, 0);
    repeat (2) add("LD_T6w", READ | MDRIN, 0, 1, 0);
    drain();
    #1 clear = 1'b0;
    #1 chk0("clr_wait");
    @(negedge clock);
    chk0("clr_hold");
    clear = 1'b1;
    add("RESET3", 20'h0, 0, 0, 1);
    i_imm(32'h6918_0005, 5'd13);
    add("T0end", PCOUT | MARIN | INCPC | ZLOWIN, ADD, 1, 1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clock  input  1  single system clock; all state changes on rising edge.
REQ-002 clear  input  1  asynchronous, active-low reset.
REQ-003 IR  input  32  current instruction: opcode IR[31:27], ra IR[26:23], rb IR[22:19], C IR[18:0].
REQ-004 CON  input  1  branch-condition flag from datapath CON logic, valid from the cycle after CONin.
REQ-005 mem_ready  input  1  memory handshake; high when Read or Write completes in the current cycle.
REQ-006 stop  input  1  pause request, sampled only at instruction boundary.
REQ-007 PCout, PCin, IncPC  output  1 each  program-counter strobes.
REQ-008 MARin, MDRin, MDRout, Read, Write  output  1 each  memory-interface strobes.
REQ-009 IRin, Yin, ZLowIn, ZLowOut, CONin  output  1 each  IR, Y, Z and CON strobes.
REQ-010 Gra, Grb, Grc, Rin, Rout, BAout, RCout  output  1 each  register-select and immediate strobes.
REQ-011 alu_op  output  5  ALU operation code, driven as the opcode or as ADD per REQ-016.
REQ-012 run  output  1  high while executing; low in HALT, PAUSE and RESET.

Function
REQ-013 The block SHALL be a Moore FSM with states RESET, T0–T7, PAUSE and HALT; every output SHALL be a pure decode of state and latched opcode class.
REQ-014 Fetch: T0 asserts PCout, MARin, IncPC, ZLowIn; T1 asserts ZLowOut, PCin, Read, MDRin and holds until mem_ready=1; T2 asserts MDRout, IRin.
REQ-015 At the end of T2 the FSM SHALL classify IR[31:27] as ALU-R (add, sub, and, or), ALU-I (addi, andi, ori), LD, LDI, ST, BR, HALT or NOP. Undefined opcodes SHALL be NOP.
REQ-016 alu_op SHALL equal the opcode in ALU-R/ALU-I T4. It SHALL be ADD in address and branch-target cycles (including T0 in every fetch) and zero otherwise.
REQ-017 ALU-R: T3 Grb,Rout,Yin; T4 Grc,Rout,ZLowIn; T5 ZLowOut,Gra,Rin; then T0.
REQ-018 ALU-I: T3 Grb,BAout,Yin; T4 RCout,ZLowIn; T5 ZLowOut,Gra,Rin; then T0.
REQ-019 LDI: T3 Grb,BAout,Yin; T4 RCout,ZLowIn; T5 ZLowOut,Gra,Rin; then T0.
REQ-020 LD: T3–T4 as LDI; T5 ZLowOut,MARin; T6 Read,MDRin held until mem_ready=1; T7 MDRout,Gra,Rin; then T0.
REQ-021 ST: T3–T5 as LD; T6 Gra,Rout,MDRin; T7 Write held until mem_ready=1; then T0.
REQ-022 BR: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 RCout,ZLowIn; T6 asserts ZLowOut,PCin only if CON=1; then T0.
REQ-023 NOP: T2 goes directly to T0.
REQ-024 HALT opcode: T2 goes to HALT, with all strobes 0 and run=0. HALT SHALL be left only by reset.
REQ-025 At every transition into T0 stop=1 SHALL redirect to PAUSE, which has all strobes 0. PAUSE SHALL exit to T0 on the first cycle stop=0.
REQ-026 A HALT opcode SHALL take priority over a simultaneous stop=1.
REQ-027 Read and Write SHALL never be asserted together. A memory wait SHALL stretch its state with all of that state's strobes held constant.

Reset
REQ-028 clear=0 SHALL force state RESET and all outputs 0 asynchronously, including mid-instruction and mid-wait.
REQ-029 The first rising edge after clear returns high SHALL move RESET to T0. run SHALL be 1 from T0 onward.

Structure
REQ-030 Package cpu_pkg SHALL hold opcode constants, the state enumeration, the opcode-class enumeration and the IR field bit positions.
REQ-031 Opcode classification SHALL be a sub-module cu_decode (opcode in, class out, combinational). control_unit SHALL register the class at the end of T2.

Verification
REQ-032 Reset, then IR=0x6918_0005 (andi R2,R3,5) with mem_ready=1 -> T3 Grb,BAout,Yin; T4 RCout,ZLowIn, alu_op=01101; T5 Gra,Rin; T0 on the 7th cycle.
REQ-033 IR=0x0090_0054 (ld R1,0x54(R2)) with mem_ready low 3 cycles in T6 -> Read,MDRin held 4 cycles; T7 MDRout,Gra,Rin; total 11 cycles.
REQ-034 IR=0x1218_0087 (st) -> T6 Gra,Rout,MDRin; T7 Write only, never with Read; return to T0.
REQ-035 BR with CON=0 -> T6 PCin=0. The same BR with CON=1 -> T6 ZLowOut,PCin=1.
REQ-036 IR=0xD800_0000 with stop=1 -> HALT, run=0, no further strobes for 20 cycles.
REQ-037 clear pulsed low during an LD T6 wait -> all outputs 0 within the same cycle; fetch restarts at T0 one edge after release.
